blend_operand_stage: RTL and testbench

Fragment-blend front end of the per-pixel pipeline. Accepts a stream of (source fragment color, framebuffer color, pixel index), selects source and destination blend factors, and drives the four operands of the downstream two-cycle saturating mixer (result = A*B + C*D). Captures the mixer result together with the delayed index into an output FIFO that can be back-pressured. The mixer has no stall input, so this block meters input acceptance with credits.

---
 rtl/blend_operand_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_blend_operand_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blend_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : blend_operand_stage
// Brief    : Fragment-blend front end. Selects source/destination blend
//            factors, drives the four operands of the external two-cycle
//            saturating mixer (A*B + C*D), realigns the mixer result with
//            its pixel index and buffers it in a first-word-fall-through
//            output FIFO. Input acceptance is metered by credits because
//            the mixer cannot be stalled.
// Revision : 1.0 - initial release
// ============================================================================
module blend_operand_stage #(
  parameter int SUB_PIXEL_WIDTH = 8,
  parameter int INDEX_WIDTH     = 16,
  parameter int FIFO_DEPTH      = 8     // power of two, at least 4
) (
  input  logic                         aclk,
  input  logic                         resetn,
  input  logic                         conf_blend_enable,
  input  logic [3:0]                   conf_src_factor,
  input  logic [3:0]                   conf_dst_factor,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [4*SUB_PIXEL_WIDTH-1:0] s_src_color,
  input  logic [4*SUB_PIXEL_WIDTH-1:0] s_dst_color,
  input  logic [INDEX_WIDTH-1:0]       s_index,
  output logic [4*SUB_PIXEL_WIDTH-1:0] mix_color_a,
  output logic [4*SUB_PIXEL_WIDTH-1:0] mix_color_b,
  output logic [4*SUB_PIXEL_WIDTH-1:0] mix_color_c,
  output logic [4*SUB_PIXEL_WIDTH-1:0] mix_color_d,
  input  logic [4*SUB_PIXEL_WIDTH-1:0] mix_result,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [4*SUB_PIXEL_WIDTH-1:0] m_color,
  output logic [INDEX_WIDTH-1:0]       m_index
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_SPW = SUB_PIXEL_WIDTH;
  localparam int c_PW  = 4 * SUB_PIXEL_WIDTH;
  localparam int c_EW  = c_PW + INDEX_WIDTH;          // FIFO entry width
  localparam int c_AW  = $clog2(FIFO_DEPTH);          // FIFO pointer width
  localparam int c_CW  = c_AW + 1;                    // count / credit width

  // Outstanding work is at most FIFO_DEPTH + 3, which still fits c_CW bits
  // for any depth of at least 4.
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);

  localparam logic [3:0] c_F_ZERO          = 4'd0;
  localparam logic [3:0] c_F_ONE           = 4'd1;
  localparam logic [3:0] c_F_DST_COLOR     = 4'd2;
  localparam logic [3:0] c_F_INV_DST_COLOR = 4'd3;
  localparam logic [3:0] c_F_SRC_ALPHA     = 4'd4;
  localparam logic [3:0] c_F_INV_SRC_ALPHA = 4'd5;
  localparam logic [3:0] c_F_DST_ALPHA     = 4'd6;
  localparam logic [3:0] c_F_INV_DST_ALPHA = 4'd7;
  localparam logic [3:0] c_F_ALPHA_SAT     = 4'd8;
  localparam logic [3:0] c_F_SRC_COLOR     = 4'd9;
  localparam logic [3:0] c_F_INV_SRC_COLOR = 4'd10;

  // --------------------------------------------------------------------------
  // Factor selection
  // --------------------------------------------------------------------------
  // Decodes one factor code into a full-pixel factor. The saturate code is
  // only meaningful as a source factor; the destination side passes
  // i_sat_allowed = 0 so that code collapses to ZERO there.
  function automatic logic [c_PW-1:0] f_factor(
    input logic [3:0]      i_code,
    input logic [c_PW-1:0] i_src,
    input logic [c_PW-1:0] i_dst,
    input logic [c_PW-1:0] i_sat,
    input logic            i_sat_allowed
  );
    logic [c_PW-1:0] w_src_alpha_rep;
    logic [c_PW-1:0] w_dst_alpha_rep;
    w_src_alpha_rep = {4{i_src[c_SPW-1:0]}};
    w_dst_alpha_rep = {4{i_dst[c_SPW-1:0]}};
    case (i_code)
      c_F_ZERO:          f_factor = '0;
      c_F_ONE:           f_factor = '1;
      c_F_DST_COLOR:     f_factor = i_dst;
      c_F_INV_DST_COLOR: f_factor = ~i_dst;
      c_F_SRC_ALPHA:     f_factor = w_src_alpha_rep;
      c_F_INV_SRC_ALPHA: f_factor = ~w_src_alpha_rep;
      c_F_DST_ALPHA:     f_factor = w_dst_alpha_rep;
      c_F_INV_DST_ALPHA: f_factor = ~w_dst_alpha_rep;
      c_F_ALPHA_SAT:     f_factor = i_sat_allowed ? i_sat : '0;
      c_F_SRC_COLOR:     f_factor = i_src;
      c_F_INV_SRC_COLOR: f_factor = ~i_src;
      default:           f_factor = '0;   // unused codes behave as ZERO
    endcase
  endfunction

  logic [c_SPW-1:0] w_src_alpha;
  logic [c_SPW-1:0] w_inv_dst_alpha;
  logic [c_SPW-1:0] w_sat_rgb;
  logic [c_PW-1:0]  w_sat_factor;
  logic [c_PW-1:0]  w_src_factor;
  logic [c_PW-1:0]  w_dst_factor;

  assign w_src_alpha     = s_src_color[c_SPW-1:0];
  assign w_inv_dst_alpha = ~s_dst_color[c_SPW-1:0];
  // min(As, ~Ad) for the RGB channels; alpha channel of the factor is one.
  assign w_sat_rgb       = (w_src_alpha < w_inv_dst_alpha) ? w_src_alpha
                                                           : w_inv_dst_alpha;
  assign w_sat_factor    = {{3{w_sat_rgb}}, {c_SPW{1'b1}}};

  assign w_src_factor = f_factor(conf_src_factor, s_src_color, s_dst_color,
                                 w_sat_factor, 1'b1);
  assign w_dst_factor = f_factor(conf_dst_factor, s_src_color, s_dst_color,
                                 w_sat_factor, 1'b0);

  // --------------------------------------------------------------------------
  // Credits
  // --------------------------------------------------------------------------
  logic                   r_ready_en;
  logic                   r_v0;
  logic                   r_v1;
  logic                   r_v2;
  logic [INDEX_WIDTH-1:0] r_idx0;
  logic [INDEX_WIDTH-1:0] r_idx1;
  logic [INDEX_WIDTH-1:0] r_idx2;
  logic [c_AW-1:0]        r_wr_ptr;
  logic [c_AW-1:0]        r_rd_ptr;
  logic [c_CW-1:0]        r_count;
  logic [c_CW-1:0]        w_outstanding;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;

  // Every fragment between acceptance and the FIFO head holds one credit,
  // so a full set of credits guarantees a free FIFO slot for each result
  // still in flight. Built from registers only.
  assign w_outstanding = r_count + c_CW'(r_v0) + c_CW'(r_v1) + c_CW'(r_v2);
  assign s_ready       = r_ready_en && (w_outstanding < c_DEPTH);
  assign w_accept      = s_valid && s_ready;

  // Holds s_ready low through reset and for the release edge itself.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 0: operand registers
  // --------------------------------------------------------------------------
  // Captures the mixer operands on acceptance; they hold otherwise, only v0
  // says whether they describe a live fragment.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_v0        <= 1'b0;
      r_idx0      <= '0;
      mix_color_a <= '0;
      mix_color_b <= '0;
      mix_color_c <= '0;
      mix_color_d <= '0;
    end else begin
      r_v0 <= w_accept;
      if (w_accept) begin
        r_idx0      <= s_index;
        mix_color_a <= s_src_color;
        if (conf_blend_enable) begin
          mix_color_b <= w_src_factor;
          mix_color_c <= s_dst_color;
          mix_color_d <= w_dst_factor;
        end else begin
          // src * all-ones + rounding 0xFF returns src exactly.
          mix_color_b <= '1;
          mix_color_c <= '0;
          mix_color_d <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stages 1-2: valid/index delay matching the mixer latency
  // --------------------------------------------------------------------------
  // Shifts valid and index so that v2/idx2 line up with mix_result.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_idx1 <= '0;
      r_idx2 <= '0;
    end else begin
      r_v1   <= r_v0;
      r_v2   <= r_v1;
      r_idx1 <= r_idx0;
      r_idx2 <= r_idx1;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // --------------------------------------------------------------------------
  logic [c_EW-1:0] r_mem [FIFO_DEPTH];
  logic [c_EW-1:0] w_head;

  assign w_push  = r_v2;
  assign m_valid = (r_count != '0);
  assign w_pop   = m_valid && m_ready;

  // Advances the FIFO pointers and occupancy; push+pop leaves count as is.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stores the realigned mixer result; storage needs no reset because the
  // read side is qualified by the occupancy count.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {mix_result, r_idx2};
    end
  end

  // Head entry is forced to zero while empty so no stale data is visible,
  // including during and right after reset.
  assign w_head             = r_mem[r_rd_ptr];
  assign {m_color, m_index} = m_valid ? w_head : '0;

  // The credit check must make overflow impossible.
  a_fifo_no_overflow: assert property (
    @(posedge aclk) disable iff (!resetn)
    !(w_push && !w_pop && (r_count == c_DEPTH))
  );

endmodule
`default_nettype wire

// File: tb/tb_blend_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_blend_operand_stage
// Brief    : Self-checking bench for blend_operand_stage with a model of the
//            two-cycle saturating mixer and a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blend_operand_stage;

  logic        aclk = 1'b0;
  logic        resetn;
  logic        conf_blend_enable;
  logic [3:0]  conf_src_factor;
  logic [3:0]  conf_dst_factor;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_src_color;
  logic [31:0] s_dst_color;
  logic [15:0] s_index;
  logic [31:0] mix_color_a, mix_color_b, mix_color_c, mix_color_d;
  logic [31:0] mix_result;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_color;
  logic [15:0] m_index;

  always #5 aclk = ~aclk;

  blend_operand_stage #(
    .SUB_PIXEL_WIDTH(8), .INDEX_WIDTH(16), .FIFO_DEPTH(8)
  ) dut (
    .aclk(aclk), .resetn(resetn),
    .conf_blend_enable(conf_blend_enable),
    .conf_src_factor(conf_src_factor), .conf_dst_factor(conf_dst_factor),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_src_color(s_src_color), .s_dst_color(s_dst_color), .s_index(s_index),
    .mix_color_a(mix_color_a), .mix_color_b(mix_color_b),
    .mix_color_c(mix_color_c), .mix_color_d(mix_color_d),
    .mix_result(mix_result),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_color(m_color), .m_index(m_index)
  );

  // --------------------------------------------------------------------------
  // Downstream mixer: per channel min(255, (a*b + c*d + 255) >> 8), 2 cycles
  // --------------------------------------------------------------------------
  function automatic logic [31:0] mix_fn(input logic [31:0] a, b, c, d);
    logic [31:0] r;
    for (int ch = 0; ch < 4; ch++) begin
      int v;
      v = (int'(a[ch*8 +: 8]) * int'(b[ch*8 +: 8]) +
           int'(c[ch*8 +: 8]) * int'(d[ch*8 +: 8]) + 255) / 256;
      if (v > 255) v = 255;
      r[ch*8 +: 8] = 8'(v);
    end
    return r;
  endfunction

  logic [31:0] mix_p1 = '0;
  logic [31:0] mix_p2 = '0;
  always @(posedge aclk) begin
    mix_p1 <= mix_fn(mix_color_a, mix_color_b, mix_color_c, mix_color_d);
    mix_p2 <= mix_p1;
  end
  assign mix_result = mix_p2;

  // --------------------------------------------------------------------------
  // Reference model: blend rules in plain integer arithmetic
  // --------------------------------------------------------------------------
  function automatic int ref_factor(input int code, input int ch,
                                    input logic [31:0] src, dst,
                                    input bit is_dst);
    int sc, dc, as_, ad;
    sc  = int'(src[ch*8 +: 8]);
    dc  = int'(dst[ch*8 +: 8]);
    as_ = int'(src[7:0]);
    ad  = int'(dst[7:0]);
    case (code)
      0:  return 0;
      1:  return 255;
      2:  return dc;
      3:  return 255 - dc;
      4:  return as_;
      5:  return 255 - as_;
      6:  return ad;
      7:  return 255 - ad;
      8:  begin
            if (is_dst) return 0;
            if (ch == 0) return 255;
            return (as_ < 255 - ad) ? as_ : 255 - ad;
          end
      9:  return sc;
      10: return 255 - sc;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_blend(input bit en, input int sf, df,
                                            input logic [31:0] src, dst);
    logic [31:0] r;
    if (!en) return src;
    for (int ch = 0; ch < 4; ch++) begin
      int v;
      v = (int'(src[ch*8 +: 8]) * ref_factor(sf, ch, src, dst, 1'b0) +
           int'(dst[ch*8 +: 8]) * ref_factor(df, ch, src, dst, 1'b1) + 255) >> 8;
      r[ch*8 +: 8] = (v > 255) ? 8'hFF : 8'(v);
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] color;
    logic [15:0] index;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        en;
    logic [3:0]  sf;
    logic [3:0]  df;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] idx;
    logic [31:0] expc;
  } vec_t;
  vec_t vecs[10];

  // Global time limit so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Waits (at posedge+1 timing) until s_ready, bounded.
  task automatic wait_ready(input string name);
    int n = 0;
    while (!s_ready && n < 30) begin
      @(posedge aclk); #1; n++;
    end
    chk(name, {63'd0, s_ready}, 64'd1);
  endtask

  // Sends one table vector alone and checks result and latency.
  task automatic run_vec(input vec_t v, input int n);
    int lat = -1;
    wait_ready($sformatf("vec%0d_ready", n));
    conf_blend_enable = v.en;
    conf_src_factor   = v.sf;
    conf_dst_factor   = v.df;
    s_src_color       = v.src;
    s_dst_color       = v.dst;
    s_index           = v.idx;
    s_valid           = 1'b1;
    m_ready           = 1'b1;
    @(posedge aclk); #1;          // acceptance edge
    s_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge aclk); #1;
      if (m_valid) begin
        lat = k + 1;
        break;
      end
    end
    chk($sformatf("vec%0d_latency", n), 64'(lat), 64'd3);
    chk($sformatf("vec%0d_color", n), {32'd0, m_color}, {32'd0, v.expc});
    chk($sformatf("vec%0d_index", n), {48'd0, m_index}, {48'd0, v.idx});
    @(posedge aclk); #1;          // popped
    chk($sformatf("vec%0d_no_dup", n), {63'd0, m_valid}, 64'd0);
  endtask

  initial begin
    int acc, pops, stale, n;
    logic took;

    // Directed vectors: {en, sf, df, src, dst, idx, expected color}
    vecs[0] = '{1'b0, 4'd0,  4'd0,  32'h12345678, 32'hDEADBEEF, 16'h0001, 32'h12345678};
    // alpha: (0x80*0x80 + 0xFF*0x7F + 0xFF) >> 8 = 0xBF
    vecs[1] = '{1'b1, 4'd4,  4'd5,  32'hFF000080, 32'h0000FFFF, 16'h0002, 32'h80007FBF};
    vecs[2] = '{1'b1, 4'd1,  4'd1,  32'hC0C0C0C0, 32'hC0C0C0C0, 16'h0003, 32'hFFFFFFFF};
    // SRC_ALPHA_SATURATE, As=0x80, Ad=0xC0 -> RGB factor 0x3F, alpha factor 0xFF
    vecs[3] = '{1'b1, 4'd8,  4'd0,  32'h40404080, 32'hFFFFFFC0, 16'h0004, 32'h10101080};
    // code 8 as destination factor behaves as ZERO
    vecs[4] = '{1'b1, 4'd1,  4'd8,  32'h11223344, 32'hFFFFFFC0, 16'h0005, 32'h11223344};
    vecs[5] = '{1'b1, 4'd12, 4'd1,  32'hAABBCCDD, 32'h01020304, 16'h0006, 32'h01020304};
    vecs[6] = '{1'b1, 4'd15, 4'd13, 32'hAABBCCDD, 32'h01020304, 16'h0007, 32'h00000000};
    vecs[7] = '{1'b1, 4'd2,  4'd3,  32'hFF00FF00, 32'h80808080, 16'h0008, 32'hBF40BF40};
    vecs[8] = '{1'b1, 4'd9,  4'd10, 32'h10FF0080, 32'hFFFFFFFF, 16'h0009, 32'hF0FFFFBF};
    vecs[9] = '{1'b1, 4'd6,  4'd7,  32'h20406080, 32'h00000040, 16'h000A, 32'h08101850};

    resetn = 1'b0;
    conf_blend_enable = 1'b0;
    conf_src_factor = '0;
    conf_dst_factor = '0;
    s_valid = 1'b0;
    s_src_color = '0;
    s_dst_color = '0;
    s_index = '0;
    m_ready = 1'b0;

    // Scoreboard: samples at negedge, i.e. the values the next edge acts on.
    fork
      forever begin
        @(negedge aclk);
        if (!resetn) begin
          sbq.delete();
        end else begin
          if (m_valid && m_ready) begin
            if (sbq.size() == 0) begin
              chk("sb_unexpected_output", {48'd0, m_index}, 64'hFFFF_FFFF);
            end else begin
              exp_t e;
              e = sbq.pop_front();
              chk("sb_color", {32'd0, m_color}, {32'd0, e.color});
              chk("sb_index", {48'd0, m_index}, {48'd0, e.index});
            end
          end
          if (s_valid && s_ready) begin
            sbq.push_back('{ref_blend(conf_blend_enable, int'(conf_src_factor),
                                      int'(conf_dst_factor), s_src_color,
                                      s_dst_color), s_index});
          end
        end
      end
    join_none

    // ---------------- reset state ----------------
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_color", {32'd0, m_color}, 64'd0);
    chk("rst_m_index", {48'd0, m_index}, 64'd0);
    chk("rst_mix_ops", {mix_color_a | mix_color_b, mix_color_c | mix_color_d}, 64'd0);
    resetn = 1'b1;
    #1;
    chk("rel_s_ready_low", {63'd0, s_ready}, 64'd0);
    @(posedge aclk); #1;
    chk("rel_s_ready_high", {63'd0, s_ready}, 64'd1);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // ---------------- back-pressure ----------------
    m_ready = 1'b0;
    conf_blend_enable = 1'b0;
    s_index = 16'h0100;
    s_src_color = 32'hA5A5A5A5;
    s_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      took = s_ready;
      if (took) acc++;
      @(posedge aclk); #1;
      if (took) begin
        s_index = s_index + 16'd1;
        s_src_color = s_src_color + 32'h01010101;
      end
    end
    chk("bp_accepts", 64'(acc), 64'd8);
    chk("bp_s_ready_low", {63'd0, s_ready}, 64'd0);
    chk("bp_m_valid", {63'd0, m_valid}, 64'd1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge aclk);
      if (m_valid) begin
        chk("bp_order", {48'd0, m_index}, 64'(16'h0100 + pops));
        pops++;
      end
      @(posedge aclk); #1;
      if (k == 0) chk("bp_ready_reassert", {63'd0, s_ready}, 64'd1);
    end
    chk("bp_pops", 64'(pops), 64'd8);

    // ---------------- random stream ----------------
    for (int k = 0; k < 3000; k++) begin
      s_valid = ($urandom_range(0, 99) < 70);
      m_ready = ($urandom_range(0, 99) < 60);
      conf_blend_enable = ($urandom_range(0, 9) != 0);
      conf_src_factor = 4'($urandom_range(0, 15));
      conf_dst_factor = 4'($urandom_range(0, 15));
      s_src_color = $urandom;
      s_dst_color = $urandom;
      s_index = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        s_src_color[7:0] = 8'h80;
        s_dst_color[7:0] = 8'hC0;
        conf_src_factor = 4'd8;
      end
      @(posedge aclk); #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    n = 0;
    while ((m_valid || sbq.size() != 0) && n < 60) begin
      @(posedge aclk); #1; n++;
    end
    chk("rand_drain_queue", 64'(sbq.size()), 64'd0);
    chk("rand_drain_m_valid", {63'd0, m_valid}, 64'd0);

    // ---------------- reset mid-operation ----------------
    m_ready = 1'b0;
    conf_blend_enable = 1'b1;
    conf_src_factor = 4'd1;
    conf_dst_factor = 4'd0;
    wait_ready("mr_ready");
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_index = 16'(16'h0200 + k);
      @(posedge aclk); #1;
    end
    s_valid = 1'b0;
    chk("mr_buffered", {63'd0, m_valid}, 64'd1);
    chk("mr_in_flight", 64'(sbq.size()), 64'd5);
    #1;
    resetn = 1'b0;
    #1;
    chk("mr_m_valid_drop", {63'd0, m_valid}, 64'd0);
    chk("mr_m_color_zero", {32'd0, m_color}, 64'd0);
    chk("mr_s_ready_low", {63'd0, s_ready}, 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    resetn = 1'b1;
    m_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge aclk); #1;
      if (m_valid) stale++;
    end
    chk("mr_no_stale", 64'(stale), 64'd0);
    chk("mr_ready_after", {63'd0, s_ready}, 64'd1);
    chk("mr_queue_empty", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
